// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for a VGA-style display. An upstream clock divider
// supplies flag_pixel, a flag that toggles at a fixed rate. Each rising edge
// of that flag is one pixel tick. Accepted ticks advance a column/line counter
// pair. Sync, blanking and start-of-line/frame strobes are decoded from the
// counts.
//
// Parameters
//   H_ACTIVE, H_FP, H_SYNC, H_BP : horizontal visible / front porch / sync /
//                                  back porch widths, in pixels
//   V_ACTIVE, V_FP, V_SYNC, V_BP : vertical visible / front porch / sync /
//                                  back porch heights, in lines
//
// Ports
//   clk          : system clock, all logic on the rising edge
//   rst          : synchronous active-high reset
//   enable       : when low, pixel ticks are dropped and the counts hold
//   flag_pixel   : toggling pixel-rate flag from the clock divider
//   h_count      : current pixel column
//   v_count      : current line
//   hsync        : horizontal sync, active low
//   vsync        : vertical sync, active low
//   display_en   : high while (h_count, v_count) is in the visible region
//   line_start   : one-clk strobe when h_count wraps to 0
//   frame_start  : one-clk strobe when both counts wrap to 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       flag_pixel,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Sync level for a given column: low only inside the sync pulse.
  function automatic logic hsync_level(input logic [9:0] h);
    return !((h >= 10'(H_SYNC_START)) && (h < 10'(H_SYNC_END)));
  endfunction

  function automatic logic vsync_level(input logic [9:0] v);
    return !((v >= 10'(V_SYNC_START)) && (v < 10'(V_SYNC_END)));
  endfunction

  function automatic logic visible(input logic [9:0] h, input logic [9:0] v);
    return (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
  endfunction

  logic       flag_d;
  logic       tick;
  logic       advance;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;

  // Stage 0: tick detection and next-count arithmetic
  always_comb begin
    tick    = flag_pixel & ~flag_d;
    advance = tick & enable;
    h_wrap  = (h_count == H_LAST);
    v_wrap  = (v_count == V_LAST);
    h_next  = h_count + 10'd1;
    v_next  = v_count;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : v_count + 10'd1;
    end
  end

  // Stage 1: counts and decoded flags register together, so they never skew.
  // flag_d resets high: a flag already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_d      <= 1'b1;
      h_count     <= '0;
      v_count     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_en  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      flag_d      <= flag_pixel;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (advance) begin
        h_count     <= h_next;
        v_count     <= v_next;
        hsync       <= hsync_level(h_next);
        vsync       <= vsync_level(v_next);
        display_en  <= visible(h_next, v_next);
        line_start  <= h_wrap;
        frame_start <= h_wrap & v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// Testbench for vga_timing_gen. A reduced raster keeps whole frames short
// enough to cross every wrap boundary several times. The reference model
// tracks a single linear pixel index within the frame and derives column,
// line and all flags from it arithmetically.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       flag_pixel;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       hsync;
  logic       vsync;
  logic       display_en;
  logic       line_start;
  logic       frame_start;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .flag_pixel(flag_pixel),
    .h_count(h_count),
    .v_count(v_count),
    .hsync(hsync),
    .vsync(vsync),
    .display_en(display_en),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int hs;
    int vs;
    int de;
    int ls;
    int fs;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;
  int n_lines  = 0;

  // Reference model state
  bit m_flag_d = 1'b1;
  int m_n      = 0;
  bit m_ls     = 1'b0;
  bit m_fs     = 1'b0;

  // Stimulus generator state
  bit fp_s   = 1'b0;
  int half_s = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t expected_now();
    exp_t e;
    e.h  = m_n % HT;
    e.v  = m_n / HT;
    e.hs = (e.h >= HA + HF && e.h < HA + HF + HS) ? 0 : 1;
    e.vs = (e.v >= VA + VF && e.v < VA + VF + VS) ? 0 : 1;
    e.de = (e.h < HA && e.v < VA) ? 1 : 0;
    e.ls = int'(m_ls);
    e.fs = int'(m_fs);
    return e;
  endfunction

  // Apply one clock of inputs, advance the model, queue the post-edge view.
  task automatic cycle(input bit r, input bit e, input bit f);
    bit t;
    rst        = r;
    enable     = e;
    flag_pixel = f;
    if (r) begin
      m_flag_d = 1'b1;
      m_n      = 0;
      m_ls     = 1'b0;
      m_fs     = 1'b0;
    end else begin
      t        = f & ~m_flag_d;
      m_flag_d = f;
      m_ls     = 1'b0;
      m_fs     = 1'b0;
      if (t && e) begin
        m_n  = (m_n + 1) % FRAME;
        m_ls = (m_n % HT) == 0;
        m_fs = (m_n == 0);
      end
    end
    @(posedge clk);
    exp_q.push_back(expected_now());
    #1;
  endtask

  // en_mode: 0 = enable high, 1 = enable randomly dropped, 2 = enable low.
  // Flag half-period is random in 1..max_half clocks.
  task automatic run(input int ncyc, input int en_mode, input int max_half);
    bit e;
    for (int i = 0; i < ncyc; i++) begin
      if (half_s == 0) begin
        fp_s   = ~fp_s;
        half_s = $urandom_range(1, max_half);
      end
      half_s--;
      case (en_mode)
        0:       e = 1'b1;
        1:       e = ($urandom_range(0, 7) != 0);
        default: e = 1'b0;
      endcase
      cycle(1'b0, e, fp_s);
    end
  endtask

  // Monitor: every clock is an output beat; compare after the edge settles.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("h_count",     int'(h_count),     e.h);
      check("v_count",     int'(v_count),     e.v);
      check("hsync",       int'(hsync),       e.hs);
      check("vsync",       int'(vsync),       e.vs);
      check("display_en",  int'(display_en),  e.de);
      check("line_start",  int'(line_start),  e.ls);
      check("frame_start", int'(frame_start), e.fs);
      if (frame_start) n_frames++;
      if (line_start)  n_lines++;
    end
  end

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    flag_pixel = 1'b0;

    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    fp_s   = 1'b0;
    half_s = 2;

    // Normal operation with occasional dropped ticks, across several frames
    run(5000, 1, 3);
    // Enable held low across many flag rising edges
    run(40, 2, 3);
    // Fastest flag: a tick every other clock
    run(1200, 0, 1);

    // Mid-frame reset with the flag held high through release
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    fp_s   = 1'b1;
    half_s = 6;
    run(3000, 1, 3);

    // Short reset pulse mid-line with enable low
    cycle(1'b1, 1'b0, fp_s);
    run(1500, 0, 2);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("frames_seen_ge2", (n_frames >= 2) ? 1 : 0, 1);
    check("lines_seen_ge_vt", (n_lines >= VT) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The block SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-010 The block SHALL have port rst, input, 1 bit, synchronous, active-high reset.
REQ-011 The block SHALL have port enable, input, 1 bit, gates counter advance.
REQ-012 The block SHALL have port flag_pixel, input, 1 bit, toggling pixel-rate flag from the upstream clock divider.
REQ-013 The block SHALL have port h_count, output, 10 bits, current pixel column.
REQ-014 The block SHALL have port v_count, output, 10 bits, current line.
REQ-015 The block SHALL have port hsync, output, 1 bit, active-low horizontal sync.
REQ-016 The block SHALL have port vsync, output, 1 bit, active-low vertical sync.
REQ-017 The block SHALL have port display_en, output, 1 bit, high in the visible region.
REQ-018 The block SHALL have port line_start, output, 1 bit, one-clk pulse at the start of each line.
REQ-019 The block SHALL have port frame_start, output, 1 bit, one-clk pulse at the start of each frame.

Function
REQ-020 The block SHALL register flag_pixel into flag_d each clk; pixel tick = flag_pixel & ~flag_d (rising edge only; falling edges ignored).
REQ-021 flag_d SHALL update every clk regardless of enable.
REQ-022 On a clk edge with tick=1 and enable=1, h_count SHALL increment; ticks with enable=0 SHALL be dropped, counts hold.
REQ-023 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); when h_count = H_TOTAL-1 and a tick is accepted, h_count SHALL wrap to 0 and v_count SHALL increment.
REQ-024 V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); when v_count = V_TOTAL-1 and h_count wraps, v_count SHALL wrap to 0.
REQ-025 All outputs SHALL be registered and updated at the same clk edge as the counts they describe (no cycle skew between counts and flags).
REQ-026 hsync SHALL be 0 iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751 default).
REQ-027 vsync SHALL be 0 iff V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491 default).
REQ-028 display_en SHALL be 1 iff h_count < H_ACTIVE and v_count < V_ACTIVE.
REQ-029 line_start SHALL be 1 for exactly one clk, the clk at which h_count becomes 0 by wrap; 0 otherwise.
REQ-030 frame_start SHALL be 1 for exactly one clk, the clk at which h_count and v_count both become 0 by wrap; line_start is also 1 then.
REQ-031 Between ticks (8 clks per pixel at divide-by-4 toggle) all outputs SHALL hold.
REQ-032 Latency: flag_pixel sampled high with flag_d=0 at edge k -> new counts and flags visible after edge k.

Reset
REQ-033 With rst=1 at a clk edge: h_count=0, v_count=0, hsync=1, vsync=1, display_en=1, line_start=0, frame_start=0, flag_d=1.
REQ-034 flag_d reset to 1 SHALL prevent a spurious tick if flag_pixel is high when rst deasserts; first tick requires an observed 0->1.
REQ-035 rst SHALL override enable and tick in the same cycle; reset mid-frame returns to (0,0) with no line_start/frame_start pulse.

Verification
REQ-036 Reset, then flag_pixel toggling every 4 clks, enable=1 -> h_count 0,1,2… advancing once per 8 clks; outputs stable between ticks.
REQ-037 Run to h_count=655 -> next tick h_count=656, hsync=0; at 752 hsync=1; at 640 display_en=0.
REQ-038 h_count=799, v_count=0, tick -> h_count=0, v_count=1, line_start=1 for one clk, frame_start=0.
REQ-039 h_count=799, v_count=524, tick -> both 0, line_start=1, frame_start=1 one clk; vsync=0 during v_count 490–491 only.
REQ-040 enable=0 across 3 rising flag_pixel edges -> counts unchanged; enable=1 -> next rising edge advances by exactly 1.
REQ-041 flag_pixel held high through rst release -> no advance until flag_pixel goes 0 then 1; assert rst at h_count=300, v_count=100 -> (0,0), hsync=1, no pulses.
